// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: fetch FSM states, opcodes and
// default widths/reset values.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection from the decoder's branch/jump controls,
// the ALU zero flag and the immediate/target fields of the instruction.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            branch_beq_i,
  input  logic            branch_bne_i,
  input  logic            jump_i,
  input  logic            zero_i,
  output logic [XLEN-1:0] next_pc_o
);

  logic [15:0]     imm;
  logic [XLEN-1:0] brTarget;
  logic [XLEN-1:0] jTarget;
  logic [XLEN-1:0] selPc;
  logic            unused_opcode;

  assign imm           = instr_i[15:0];
  assign brTarget      = pc_plus4_i + {{14{imm[15]}}, imm, 2'b00};
  assign jTarget       = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
  assign unused_opcode = ^instr_i[31:26];

  // Controls the decoder leaves undriven fail every if-test, so they fall through to pc+4.
  always_comb begin
    selPc = pc_plus4_i;
    if (jump_i == 1'b1) begin
      selPc = jTarget;
    end else if (branch_beq_i == 1'b1 && zero_i == 1'b1) begin
      selPc = brTarget;
    end else if (branch_bne_i == 1'b1 && zero_i == 1'b0) begin
      selPc = brTarget;
    end
  end

  assign next_pc_o = {selPc[XLEN-1:2], 2'b00};

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, instruction register and the
// IDLE/FETCH/EXEC sequencer driving the instruction-memory handshake.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_instr,
  output logic            o_instr_valid,
  input  logic            i_stall,
  input  logic            i_branch_beq,
  input  logic            i_branch_bne,
  input  logic            i_jump,
  input  logic            i_zero,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] nextPc;

  assign pcPlus4 = pc_q + XLEN'(4);

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i   (pcPlus4),
    .instr_i      (instr_q),
    .branch_beq_i (i_branch_beq),
    .branch_bne_i (i_branch_bne),
    .jump_i       (i_jump),
    .zero_i       (i_zero),
    .next_pc_o    (nextPc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ready) begin
          instr_d = i_imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!i_stall) begin
          pc_d    = nextPc;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset wins over any response arriving in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign o_imem_req    = (state_q == S_FETCH);
  assign o_imem_addr   = pc_q;
  assign o_instr       = instr_q;
  assign o_instr_valid = (state_q == S_EXEC);
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pcPlus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// run compared against an arithmetic next-PC reference model.
module tb_fetch_pc_unit;

  localparam logic [31:0] ADDI_INSTR = 32'h2021_0005;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        i_stall;
  logic        i_branch_beq;
  logic        i_branch_bne;
  logic        i_jump;
  logic        i_zero;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic [31:0] obsAddr, obsInstr, obsPc, obsPlus4;
  logic        obsValid;
  bit          obsFetchOk, obsExecOk;

  always #5 i_clk = ~i_clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .i_stall       (i_stall),
    .i_branch_beq  (i_branch_beq),
    .i_branch_bne  (i_branch_bne),
    .i_jump        (i_jump),
    .i_zero        (i_zero),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4)
  );

  // Reference next-PC written from the architectural rules with plain arithmetic.
  function automatic logic [31:0] refNextPc(input logic [31:0] pc, input logic [31:0] instr,
                                            input logic beq, input logic bne,
                                            input logic jmp, input logic zero);
    logic [31:0] p4;
    int          offset;
    p4     = pc + 32'd4;
    offset = int'($signed(instr[15:0])) * 4;
    if (jmp === 1'b1)
      return (p4 & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
    if (beq === 1'b1 && zero === 1'b1)
      return p4 + 32'(offset);
    if (bne === 1'b1 && zero === 1'b0)
      return p4 + 32'(offset);
    return p4;
  endfunction

  function automatic logic [31:0] mkJump(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

  function automatic logic [31:0] mkBranch(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 5'd1, 5'd2, imm};
  endfunction

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic randomControls();
    i_branch_beq = 1'($urandom);
    i_branch_bne = 1'($urandom);
    i_jump       = 1'($urandom);
    i_zero       = 1'($urandom);
  endtask

  // Runs one fetch/execute step from the start of a FETCH cycle and records what it saw.
  task automatic doStep(input logic [31:0] rdata, input int waitC, input int stallC,
                        input logic beq, input logic bne, input logic jmp, input logic zero);
    obsAddr    = o_imem_addr;
    obsFetchOk = 1'b1;
    for (int k = 0; k <= waitC; k++) begin
      if (o_imem_req !== 1'b1 || o_imem_addr !== obsAddr || o_instr_valid !== 1'b0)
        obsFetchOk = 1'b0;
      i_imem_ready = (k == waitC);
      i_imem_rdata = (k == waitC) ? rdata : $urandom;
      i_stall      = 1'($urandom);
      randomControls();
      cycle();
    end
    i_imem_rdata = $urandom;
    obsInstr  = o_instr;
    obsValid  = o_instr_valid;
    obsPc     = o_pc;
    obsPlus4  = o_pc_plus4;
    obsExecOk = (o_imem_req === 1'b0);
    for (int k = 0; k < stallC; k++) begin
      i_stall      = 1'b1;
      i_imem_ready = 1'($urandom);
      randomControls();
      cycle();
      if (o_instr !== obsInstr || o_pc !== obsPc || o_imem_addr !== obsPc ||
          o_imem_req !== 1'b0 || o_instr_valid !== 1'b1)
        obsExecOk = 1'b0;
    end
    i_stall      = 1'b0;
    i_imem_ready = 1'($urandom);
    i_branch_beq = beq;
    i_branch_bne = bne;
    i_jump       = jmp;
    i_zero       = zero;
    cycle();
    i_imem_ready = 1'b0;
    i_branch_beq = 1'b0;
    i_branch_bne = 1'b0;
    i_jump       = 1'b0;
    i_zero       = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_imem_ready = 1'b1; i_imem_rdata = 32'hDEAD_BEEF; i_stall = 1'b0;
    i_branch_beq = 1'b0; i_branch_bne = 1'b0; i_jump = 1'b0; i_zero = 1'b0;
    cycle();
    cycle();
    checksTotal++;
    if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0)
      $display("[TB] FAIL reset_ctrl got req=%b valid=%b expected 0/0", o_imem_req, o_instr_valid);
    else checksPassed++;
    checksTotal++;
    if (o_instr !== 32'h0 || o_pc !== 32'h0)
      $display("[TB] FAIL reset_regs got instr=%h pc=%h expected 0/0", o_instr, o_pc);
    else checksPassed++;
    i_rst = 1'b0; i_imem_ready = 1'b0;
    checksTotal++;
    if (o_imem_req !== 1'b0)
      $display("[TB] FAIL idle_cycle got req=%b expected 0", o_imem_req);
    else checksPassed++;
    cycle();
    checksTotal++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0)
      $display("[TB] FAIL first_fetch got req=%b addr=%h expected 1/00000000", o_imem_req, o_imem_addr);
    else checksPassed++;
  endtask

  task automatic test_sequential();
    logic [31:0] expAddr [3] = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      doStep(ADDI_INSTR, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      checksTotal++;
      if (obsAddr !== expAddr[i] || obsPc !== expAddr[i])
        $display("[TB] FAIL seq_addr%0d got addr=%h pc=%h expected %h", i, obsAddr, obsPc, expAddr[i]);
      else checksPassed++;
      checksTotal++;
      if (!obsFetchOk || obsValid !== 1'b1 || obsInstr !== ADDI_INSTR)
        $display("[TB] FAIL seq_valid%0d got fetchOk=%0d valid=%b instr=%h expected 1/1/%h",
                 i, obsFetchOk, obsValid, obsInstr, ADDI_INSTR);
      else checksPassed++;
    end
    checksTotal++;
    if (o_imem_addr !== 32'hC)
      $display("[TB] FAIL seq_next got addr=%h expected 0000000c", o_imem_addr);
    else checksPassed++;
  endtask

  task automatic test_branch();
    doStep(mkJump(6'h02, 26'h10), 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checksTotal++;
    if (o_imem_addr !== 32'h40)
      $display("[TB] FAIL j_to_40 got addr=%h expected 00000040", o_imem_addr);
    else checksPassed++;
    doStep(mkBranch(6'h04, 16'hFFFE), 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    checksTotal++;
    if (o_imem_addr !== 32'h3C)
      $display("[TB] FAIL beq_taken got addr=%h expected 0000003c", o_imem_addr);
    else checksPassed++;
    doStep(mkJump(6'h02, 26'h10), 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    doStep(mkBranch(6'h04, 16'hFFFE), 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    checksTotal++;
    if (o_imem_addr !== 32'h44)
      $display("[TB] FAIL beq_not_taken got addr=%h expected 00000044", o_imem_addr);
    else checksPassed++;
  endtask

  task automatic test_jump();
    doStep(mkJump(6'h02, 26'h3FF_FFFF), 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    doStep(mkJump(6'h02, 26'h000_0004), 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checksTotal++;
    if (o_imem_addr !== 32'h1000_0010)
      $display("[TB] FAIL j_region got addr=%h expected 10000010", o_imem_addr);
    else checksPassed++;
    doStep(mkJump(6'h02, 26'h000_0100), 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checksTotal++;
    if (o_imem_addr !== 32'h1000_0400)
      $display("[TB] FAIL j_target got addr=%h expected 10000400", o_imem_addr);
    else checksPassed++;
    doStep(mkJump(6'h02, 26'h000_0004), 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    doStep(mkJump(6'h03, 26'h000_0100), 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checksTotal++;
    if (obsPlus4 !== 32'h1000_0014 || o_imem_addr !== 32'h1000_0400)
      $display("[TB] FAIL jal got plus4=%h addr=%h expected 10000014/10000400", obsPlus4, o_imem_addr);
    else checksPassed++;
  endtask

  task automatic test_stall();
    doStep(ADDI_INSTR, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    checksTotal++;
    if (!obsExecOk || obsPc !== 32'h1000_0400)
      $display("[TB] FAIL stall_hold got execOk=%0d pc=%h expected 1/10000400", obsExecOk, obsPc);
    else checksPassed++;
    checksTotal++;
    if (o_imem_addr !== 32'h1000_0404 || o_instr_valid !== 1'b0)
      $display("[TB] FAIL stall_release got addr=%h valid=%b expected 10000404/0", o_imem_addr, o_instr_valid);
    else checksPassed++;
  endtask

  task automatic test_reset_mid_wait();
    bit stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_imem_ready = 1'b0;
      cycle();
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h1000_0404) stable = 1'b0;
    end
    checksTotal++;
    if (!stable)
      $display("[TB] FAIL wait_stable got stable=%0d expected 1 (addr=%h)", stable, o_imem_addr);
    else checksPassed++;
    i_rst = 1'b1; i_imem_ready = 1'b1; i_imem_rdata = ADDI_INSTR;
    cycle();
    i_rst = 1'b0; i_imem_ready = 1'b0;
    checksTotal++;
    if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0 || o_instr !== 32'h0 || o_pc !== 32'h0)
      $display("[TB] FAIL rst_mid got req=%b valid=%b instr=%h pc=%h expected 0/0/0/0",
               o_imem_req, o_instr_valid, o_instr, o_pc);
    else checksPassed++;
    cycle();
    checksTotal++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_instr !== 32'h0)
      $display("[TB] FAIL rst_refetch got req=%b addr=%h instr=%h expected 1/0/0",
               o_imem_req, o_imem_addr, o_instr);
    else checksPassed++;
  endtask

  task automatic test_illegal_and_wrap();
    doStep(32'hFC00_1234, 0, 0, 1'bx, 1'bx, 1'bx, 1'bx);
    checksTotal++;
    if (o_imem_addr !== 32'h4)
      $display("[TB] FAIL illegal got addr=%h expected 00000004", o_imem_addr);
    else checksPassed++;
    doStep(mkBranch(6'h04, 16'h8000), 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    checksTotal++;
    if (o_imem_addr !== 32'hFFFE_0008)
      $display("[TB] FAIL beq_wrap_back got addr=%h expected fffe0008", o_imem_addr);
    else checksPassed++;
    doStep(mkJump(6'h02, 26'h3FF_FFFF), 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    doStep(ADDI_INSTR, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checksTotal++;
    if (obsPc !== 32'hFFFF_FFFC || obsPlus4 !== 32'h0 || o_imem_addr !== 32'h0)
      $display("[TB] FAIL wrap got pc=%h plus4=%h addr=%h expected fffffffc/0/0", obsPc, obsPlus4, o_imem_addr);
    else checksPassed++;
  endtask

  task automatic test_random();
    logic [31:0] expPc = 32'h0;
    logic [31:0] instr;
    logic        beq, bne, jmp, zero;
    for (int i = 0; i < 150; i++) begin
      instr = $urandom;
      beq   = ($urandom_range(0, 2) == 0);
      bne   = ($urandom_range(0, 2) == 0);
      jmp   = ($urandom_range(0, 5) == 0);
      zero  = 1'($urandom);
      doStep(instr, $urandom_range(0, 3), $urandom_range(0, 2), beq, bne, jmp, zero);
      checksTotal++;
      if (obsAddr !== expPc || obsPc !== expPc || obsPlus4 !== expPc + 32'd4)
        $display("[TB] FAIL rand_pc%0d got addr=%h pc=%h plus4=%h expected pc %h",
                 i, obsAddr, obsPc, obsPlus4, expPc);
      else checksPassed++;
      checksTotal++;
      if (obsInstr !== instr || obsValid !== 1'b1 || !obsFetchOk || !obsExecOk)
        $display("[TB] FAIL rand_instr%0d got instr=%h valid=%b fetchOk=%0d execOk=%0d expected %h/1/1/1",
                 i, obsInstr, obsValid, obsFetchOk, obsExecOk, instr);
      else checksPassed++;
      expPc = refNextPc(expPc, instr, beq, bne, jmp, zero);
    end
    checksTotal++;
    if (o_imem_addr !== expPc)
      $display("[TB] FAIL rand_final got addr=%h expected %h", o_imem_addr, expPc);
    else checksPassed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid_wait();
    test_illegal_and_wrap();
    test_random();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
